// File: rtl/fft_pkg.sv
// Shared FFT datapath types: complex sample, magnitude word and serializer states.
package fft_pkg;
  localparam int FFT_N     = 32;
  localparam int BIN_IDX_W = 5;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

  typedef logic [16:0] mag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } fft_ser_state_e;
endpackage

// File: rtl/fft_mag_peak_serializer_if.sv
// Frame-capture, magnitude-stream and peak-report signals of the FFT output stage.
interface fft_mag_peak_serializer_if #(
  parameter int N_BINS = 32,
  parameter int MAG_W  = 17
);
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [N_BINS*16-1:0] in_re;
  logic [N_BINS*16-1:0] in_im;
  logic                 m_valid;
  logic                 m_ready;
  logic [MAG_W-1:0]     m_data;
  logic [BIN_IDX_W-1:0] m_bin;
  logic                 m_last;
  logic                 peak_valid;
  logic [BIN_IDX_W-1:0] peak_bin;
  logic [MAG_W-1:0]     peak_mag;

  modport master (
    output in_valid, in_re, in_im, m_ready,
    input  in_ready, m_valid, m_data, m_bin, m_last, peak_valid, peak_bin, peak_mag
  );

  modport slave (
    input  in_valid, in_re, in_im, m_ready,
    output in_ready, m_valid, m_data, m_bin, m_last, peak_valid, peak_bin, peak_mag
  );
endinterface

// File: rtl/fft_mag_approx.sv
// Alpha-max-beta-min magnitude: max(|re|,|im|) + min(|re|,|im|)/2, combinational.
module fft_mag_approx
  import fft_pkg::*;
(
  input  cplx16_t c,
  output mag_t    mag
);
  logic [15:0] a, b, hi, lo;

  always_comb begin
    // Two's-complement negate in 16 bits maps -32768 to 0x8000 = 32768 unsigned.
    a   = c.re[15] ? (~c.re + 16'd1) : c.re;
    b   = c.im[15] ? (~c.im + 16'd1) : c.im;
    hi  = (a > b) ? a : b;
    lo  = (a > b) ? b : a;
    mag = {1'b0, hi} + {2'b00, lo[15:1]};
  end
endmodule

// File: rtl/fft_mag_peak_serializer.sv
// Captures a 32-bin FFT frame, streams per-bin magnitudes and reports the peak bin.
// Optional FFT_MAG_OVERRUN_CNT_EN adds a saturating dropped-frame counter output.
module fft_mag_peak_serializer
  import fft_pkg::*;
#(
  parameter int N_BINS  = FFT_N,
  parameter int N_OUT   = 16,
  parameter int SKIP_DC = 1,
  parameter int MAG_W   = 17
) (
  input logic clk_100MHz,
  input logic rstn,
  fft_mag_peak_serializer_if.slave bus
`ifdef FFT_MAG_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);
  localparam logic [BIN_IDX_W-1:0] FIRST_BIN = (SKIP_DC != 0) ? BIN_IDX_W'(1) : '0;
  localparam logic [BIN_IDX_W-1:0] LAST_BIN  = BIN_IDX_W'(N_OUT - 1);

  fft_ser_state_e state_reg, state_next;
  logic in_ready, peak_valid;

  cplx16_t in_frame  [N_BINS];
  cplx16_t frame_reg [N_BINS];

  logic                 m_valid_reg, m_last_reg;
  logic [MAG_W-1:0]     m_data_reg;
  logic [BIN_IDX_W-1:0] m_bin_reg;
  logic [MAG_W-1:0]     run_mag_reg, peak_mag_reg;
  logic [BIN_IDX_W-1:0] run_bin_reg, peak_bin_reg;

  logic                 capture, beat_done, eligible, peak_upd;
  logic [BIN_IDX_W-1:0] rd_idx;
  cplx16_t              mag_src;
  mag_t                 mag_val;

  for (genvar gi = 0; gi < N_BINS; gi++) begin : g_unpack
    assign in_frame[gi] = {bus.in_re[16*gi +: 16], bus.in_im[16*gi +: 16]};
  end

  assign capture   = (state_reg == IDLE) && bus.in_valid;
  assign beat_done = (state_reg == STREAM) && m_valid_reg && bus.m_ready;
  assign eligible  = (SKIP_DC == 0) || (m_bin_reg != '0);
  assign peak_upd  = beat_done && eligible && (m_data_reg > run_mag_reg);
  assign rd_idx    = m_bin_reg + 1'b1;

  // Bin 0 is computed straight from the input so its beat is ready the cycle after capture.
  assign mag_src = (state_reg == IDLE) ? in_frame[0] : frame_reg[rd_idx];

  fft_mag_approx u_mag (
    .c   (mag_src),
    .mag (mag_val)
  );

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = STREAM;
      STREAM:  if (beat_done && m_last_reg) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    peak_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready = 1'b1;
      REPORT:  peak_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (capture) begin
      for (int i = 0; i < N_BINS; i++) frame_reg[i] <= in_frame[i];
    end
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      m_data_reg   <= '0;
      m_bin_reg    <= '0;
      run_mag_reg  <= '0;
      run_bin_reg  <= '0;
      peak_mag_reg <= '0;
      peak_bin_reg <= '0;
    end else if (capture) begin
      m_valid_reg <= 1'b1;
      m_last_reg  <= (N_OUT == 1);
      m_data_reg  <= MAG_W'(mag_val);
      m_bin_reg   <= '0;
      run_mag_reg <= '0;
      run_bin_reg <= FIRST_BIN;
    end else if (beat_done) begin
      if (peak_upd) begin
        run_mag_reg <= m_data_reg;
        run_bin_reg <= m_bin_reg;
      end
      if (m_last_reg) begin
        // Publish the running peak including this final beat's contribution.
        m_valid_reg  <= 1'b0;
        peak_mag_reg <= peak_upd ? m_data_reg : run_mag_reg;
        peak_bin_reg <= peak_upd ? m_bin_reg  : run_bin_reg;
      end else begin
        m_bin_reg  <= rd_idx;
        m_data_reg <= MAG_W'(mag_val);
        m_last_reg <= (rd_idx == LAST_BIN);
      end
    end
  end

`ifdef FFT_MAG_OVERRUN_CNT_EN
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) overrun_cnt <= '0;
    else if (bus.in_valid && !in_ready && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

  assign bus.in_ready   = in_ready;
  assign bus.m_valid    = m_valid_reg;
  assign bus.m_data     = m_data_reg;
  assign bus.m_bin      = m_bin_reg;
  assign bus.m_last     = m_last_reg;
  assign bus.peak_valid = peak_valid;
  assign bus.peak_bin   = peak_bin_reg;
  assign bus.peak_mag   = peak_mag_reg;
endmodule
